pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter LOAD_LAT, default 1, range 1..4: bubble cycles inserted per load-use hazard.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port loads_ex  input  1  load instruction held in read-register/EX stage, from that stage's loads output.
REQ-005 SHALL have port num_Rd_ex  input  3  destination register of the EX-stage instruction.
REQ-006 SHALL have port valid_id  input  1  decode stage holds a real instruction.
REQ-007 SHALL have port num_Rm_id, num_Rn_id, num_Rd_id  input  3 each  decode-stage register numbers.
REQ-008 SHALL have port used_RmRnRd_id  input  3  decode-stage source-use flags: bit2 Rm, bit1 Rn, bit0 Rd read as source.
REQ-009 SHALL have port branch_taken  input  1  EX-stage branch resolved taken.
REQ-010 SHALL have port mem_busy  input  1  memory stage cannot complete this cycle.
REQ-011 SHALL have ports update_if, update_id, update_ex, update_mem  output  1 each  pipeline-register update enables.
REQ-012 SHALL have ports flush_id, flush_ex  output  1 each  load a bubble (zero control) into that stage's register this edge.
REQ-013 SHALL have port state  output  2  current FSM state: RUN=0, LSTALL=1, MWAIT=2, FLUSH=3.
REQ-014 SHALL have port stall_cnt  output  16  saturating count of cycles with update_id=0.

Function
REQ-015 SHALL define hazard = loads_ex & valid_id & ((used[2]&Rm_id==Rd_ex) | (used[1]&Rn_id==Rd_ex) | (used[0]&Rd_id==Rd_ex)).
REQ-016 SHALL drive outputs combinationally from state and the current cycle's inputs, with event priority mem_busy > branch_taken > hazard.
REQ-017 RUN, no event: SHALL drive all update_*=1 and flush_*=0, and remain in RUN.
REQ-018 Any state except MWAIT, mem_busy=1: SHALL drive all update_*=0 and flush_*=0, save the current state and counter to ret_state, and go to MWAIT.
REQ-019 MWAIT: SHALL drive all update_*=0; when mem_busy=0, SHALL restore ret_state and counter and drive that state's outputs the same cycle.
REQ-020 RUN, branch_taken: SHALL drive update_*=1, flush_id=1 and flush_ex=0, then go to FLUSH.
REQ-021 FLUSH: SHALL drive update_*=1, flush_id=1 and ignore hazard, then go to RUN; branch_taken in FLUSH SHALL restart FLUSH.
REQ-022 RUN, hazard: SHALL drive update_if=update_id=0, update_ex=update_mem=1, flush_ex=1.
REQ-023 On hazard with LOAD_LAT=1, SHALL remain in RUN.
REQ-024 On hazard with LOAD_LAT>=2, SHALL load the counter with LOAD_LAT-2 and go to LSTALL.
REQ-025 LSTALL: SHALL drive the REQ-022 outputs; at counter=0 SHALL go to RUN, otherwise decrement.
REQ-026 branch_taken in LSTALL SHALL take effect: drive REQ-020 outputs and go to FLUSH, abandoning the stall.
REQ-027 stall_cnt SHALL increment on every non-reset cycle with update_id=0 and saturate at 0xFFFF without wrap.
REQ-028 A held branch_taken or hazard during MWAIT SHALL be evaluated on the exit cycle, with no loss or duplication.

Reset
REQ-029 While rst=1, SHALL drive update_*=0 and flush_*=0 combinationally.
REQ-030 On a clock edge with rst=1, SHALL set state=RUN, ret_state=RUN, counter=0 and stall_cnt=0.
REQ-031 rst SHALL override any in-progress LSTALL, MWAIT or FLUSH at that edge; the first cycle after rst falls behaves as RUN.

Verification
REQ-032 LOAD_LAT=1; loads_ex=1, Rd_ex=3, valid_id=1, used=100, Rm_id=3 for 1 cycle -> update_if/id=0, flush_ex=1 for 1 cycle; stall_cnt=1; state stays 0.
REQ-033 LOAD_LAT=3; same hazard -> state 1 for 2 cycles, 3 bubble cycles total; stall_cnt=3.
REQ-034 Hazard with Rm_id=3, used=000 -> no stall; all update_*=1.
REQ-035 LSTALL with counter=1; mem_busy=1 for 4 cycles -> state 2, all update_*=0; after release, LSTALL resumes with 1 cycle left; stall_cnt +6.
REQ-036 RUN; branch_taken and hazard together -> flush_id=1 for 2 cycles (states 3 then 0), no flush_ex, update_id=1 throughout.
REQ-037 stall_cnt preloaded to 0xFFFE; 3 stall cycles -> 0xFFFF, holds. rst mid-MWAIT -> next cycle state 0, stall_cnt 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module      : pipeline_hazard_ctrl
// Description : Pipeline hazard controller for a 5-stage in-order core.
//               Generates per-stage update enables and bubble (flush) strobes
//               from load-use hazards, taken branches and memory back-pressure.
//               Tracks a saturating count of front-end stall cycles.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int LOAD_LAT = 1    // bubble cycles per load-use hazard, 1..4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        loads_ex,
  input  logic [2:0]  num_Rd_ex,
  input  logic        valid_id,
  input  logic [2:0]  num_Rm_id,
  input  logic [2:0]  num_Rn_id,
  input  logic [2:0]  num_Rd_id,
  input  logic [2:0]  used_RmRnRd_id,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        update_if,
  output logic        update_id,
  output logic        update_ex,
  output logic        update_mem,
  output logic        flush_id,
  output logic        flush_ex,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_MWAIT  = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  // Remaining LSTALL cycles after the hazard cycle itself; the hazard cycle
  // and the final LSTALL cycle (counter == 0) each account for one bubble.
  localparam logic [1:0] C_LSTALL_INIT = (LOAD_LAT >= 2) ? 2'(LOAD_LAT - 2) : 2'd0;

  state_t      state_q, state_d;
  state_t      ret_state_q, ret_state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  ret_cnt_q, ret_cnt_d;
  logic [15:0] stall_cnt_q;

  logic        hazard;
  state_t      eff_state;
  logic [1:0]  eff_cnt;

  // Load-use hazard: EX load writes a register the decode instruction reads.
  always_comb begin
    hazard = loads_ex & valid_id &
             ((used_RmRnRd_id[2] & (num_Rm_id == num_Rd_ex)) |
              (used_RmRnRd_id[1] & (num_Rn_id == num_Rd_ex)) |
              (used_RmRnRd_id[0] & (num_Rd_id == num_Rd_ex)));
  end

  // When leaving MWAIT, behave this very cycle as the state that was parked.
  always_comb begin
    if (state_q == ST_MWAIT) begin
      eff_state = ret_state_q;
      eff_cnt   = ret_cnt_q;
    end else begin
      eff_state = state_q;
      eff_cnt   = cnt_q;
    end
  end

  // Next-state and output decode, priority mem_busy > branch_taken > hazard.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ret_state_d = ret_state_q;
    ret_cnt_d   = ret_cnt_q;
    update_if   = 1'b0;
    update_id   = 1'b0;
    update_ex   = 1'b0;
    update_mem  = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;

    if (rst) begin
      // Everything frozen; registers are cleared by the sequential block.
    end else if (mem_busy) begin
      // Whole pipe freezes; park the current context on entry to MWAIT only,
      // so a long wait keeps the context captured on its first cycle.
      if (state_q != ST_MWAIT) begin
        ret_state_d = state_q;
        ret_cnt_d   = cnt_q;
        state_d     = ST_MWAIT;
      end
    end else begin
      cnt_d = eff_cnt;
      case (eff_state)
        ST_RUN: begin
          if (branch_taken) begin
            update_if  = 1'b1;
            update_id  = 1'b1;
            update_ex  = 1'b1;
            update_mem = 1'b1;
            flush_id   = 1'b1;
            state_d    = ST_FLUSH;
          end else if (hazard) begin
            update_ex  = 1'b1;
            update_mem = 1'b1;
            flush_ex   = 1'b1;
            if (LOAD_LAT >= 2) begin
              cnt_d   = C_LSTALL_INIT;
              state_d = ST_LSTALL;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            update_if  = 1'b1;
            update_id  = 1'b1;
            update_ex  = 1'b1;
            update_mem = 1'b1;
            state_d    = ST_RUN;
          end
        end

        ST_LSTALL: begin
          if (branch_taken) begin
            // The stalled decode instruction is on the wrong path; drop it.
            update_if  = 1'b1;
            update_id  = 1'b1;
            update_ex  = 1'b1;
            update_mem = 1'b1;
            flush_id   = 1'b1;
            state_d    = ST_FLUSH;
          end else begin
            update_ex  = 1'b1;
            update_mem = 1'b1;
            flush_ex   = 1'b1;
            if (eff_cnt == 2'd0) begin
              state_d = ST_RUN;
            end else begin
              cnt_d   = eff_cnt - 2'd1;
              state_d = ST_LSTALL;
            end
          end
        end

        ST_FLUSH: begin
          // Second wrong-path slot; any hazard it shows is irrelevant.
          update_if  = 1'b1;
          update_id  = 1'b1;
          update_ex  = 1'b1;
          update_mem = 1'b1;
          flush_id   = 1'b1;
          state_d    = branch_taken ? ST_FLUSH : ST_RUN;
        end

        default: begin
          // A parked MWAIT context cannot occur; recover to RUN.
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State, parked context and saturating stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      ret_state_q <= ST_RUN;
      cnt_q       <= 2'd0;
      ret_cnt_q   <= 2'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      cnt_q       <= cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      if (!update_id && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed bench for pipeline_hazard_ctrl. Two instances
//               (LOAD_LAT=1 and LOAD_LAT=3) share one stimulus stream.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       loads_ex;
  logic [2:0] num_Rd_ex;
  logic       valid_id;
  logic [2:0] num_Rm_id;
  logic [2:0] num_Rn_id;
  logic [2:0] num_Rd_id;
  logic [2:0] used_RmRnRd_id;
  logic       branch_taken;
  logic       mem_busy;

  logic        a_uif, a_uid, a_uex, a_umem, a_fid, a_fex;
  logic [1:0]  a_state;
  logic [15:0] a_cnt;
  logic        b_uif, b_uid, b_uex, b_umem, b_fid, b_fex;
  logic [1:0]  b_state;
  logic [15:0] b_cnt;

  int vectors;
  int miscompares;

  // Output bundles {update_if, update_id, update_ex, update_mem, flush_id, flush_ex}
  localparam logic [5:0] C_ALL    = 6'b111100;
  localparam logic [5:0] C_ZERO   = 6'b000000;
  localparam logic [5:0] C_BUBBLE = 6'b001101;
  localparam logic [5:0] C_BRANCH = 6'b111110;

  logic [5:0] a_out, b_out;
  assign a_out = {a_uif, a_uid, a_uex, a_umem, a_fid, a_fex};
  assign b_out = {b_uif, b_uid, b_uex, b_umem, b_fid, b_fex};

  pipeline_hazard_ctrl #(.LOAD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .loads_ex(loads_ex), .num_Rd_ex(num_Rd_ex),
    .valid_id(valid_id), .num_Rm_id(num_Rm_id), .num_Rn_id(num_Rn_id),
    .num_Rd_id(num_Rd_id), .used_RmRnRd_id(used_RmRnRd_id),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .update_if(a_uif), .update_id(a_uid), .update_ex(a_uex), .update_mem(a_umem),
    .flush_id(a_fid), .flush_ex(a_fex), .state(a_state), .stall_cnt(a_cnt)
  );

  pipeline_hazard_ctrl #(.LOAD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .loads_ex(loads_ex), .num_Rd_ex(num_Rd_ex),
    .valid_id(valid_id), .num_Rm_id(num_Rm_id), .num_Rn_id(num_Rn_id),
    .num_Rd_id(num_Rd_id), .used_RmRnRd_id(used_RmRnRd_id),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .update_if(b_uif), .update_id(b_uid), .update_ex(b_uex), .update_mem(b_umem),
    .flush_id(b_fid), .flush_ex(b_fex), .state(b_state), .stall_cnt(b_cnt)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    loads_ex       = 1'b0;
    num_Rd_ex      = 3'd0;
    valid_id       = 1'b0;
    num_Rm_id      = 3'd0;
    num_Rn_id      = 3'd0;
    num_Rd_id      = 3'd0;
    used_RmRnRd_id = 3'b000;
    branch_taken   = 1'b0;
    mem_busy       = 1'b0;
  endtask

  // Load into r3 in EX, decode instruction reads r3 through Rm.
  task automatic rm_hazard();
    loads_ex       = 1'b1;
    num_Rd_ex      = 3'd3;
    valid_id       = 1'b1;
    num_Rm_id      = 3'd3;
    num_Rn_id      = 3'd5;
    num_Rd_id      = 3'd6;
    used_RmRnRd_id = 3'b100;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    idle();

    // Reset: outputs held low, registers cleared.
    tick();
    tick();
    #1;
    chk("rst_out_1", a_out, C_ZERO);
    chk("rst_out_3", b_out, C_ZERO);
    chk("rst_state", a_state, 2'd0);
    chk("rst_cnt",   a_cnt, 16'd0);
    rst = 1'b0;
    #1;
    chk("run_idle_1", a_out, C_ALL);
    chk("run_idle_3", b_out, C_ALL);

    // Matching register but no use flag -> no stall.
    rm_hazard();
    used_RmRnRd_id = 3'b000;
    #1;
    chk("nouse_1", a_out, C_ALL);
    chk("nouse_3", b_out, C_ALL);
    // Rn used but does not match -> no stall.
    used_RmRnRd_id = 3'b010;
    #1;
    chk("rn_nomatch", a_out, C_ALL);
    // Rd read as source and matching -> hazard.
    used_RmRnRd_id = 3'b001;
    num_Rd_id      = 3'd3;
    #1;
    chk("rd_hazard", a_out, C_BUBBLE);
    idle();
    tick();

    // Load-use hazard for one cycle.
    rm_hazard();
    #1;
    chk("haz_1", a_out, C_BUBBLE);
    chk("haz_3", b_out, C_BUBBLE);
    tick();
    idle();
    #1;
    chk("lat1_state", a_state, 2'd0);
    chk("lat1_cnt",   a_cnt, 16'd1);
    chk("lat1_out",   a_out, C_ALL);
    chk("lat3_st_a",  b_state, 2'd1);
    chk("lat3_out_a", b_out, C_BUBBLE);
    tick();
    chk("lat3_st_b",  b_state, 2'd1);
    chk("lat3_out_b", b_out, C_BUBBLE);
    tick();
    chk("lat3_st_c",  b_state, 2'd0);
    chk("lat3_out_c", b_out, C_ALL);
    chk("lat3_cnt",   b_cnt, 16'd3);

    // Memory wait interrupting LSTALL with one cycle of counter left.
    rm_hazard();
    tick();
    idle();
    mem_busy = 1'b1;
    #1;
    chk("mw_enter_st", b_state, 2'd1);
    chk("mw_enter_3",  b_out, C_ZERO);
    chk("mw_enter_1",  a_out, C_ZERO);
    tick();
    chk("mw_state",    b_state, 2'd2);
    chk("mw_out_3",    b_out, C_ZERO);
    tick();
    tick();
    chk("mw_state_4",  b_state, 2'd2);
    tick();
    mem_busy = 1'b0;
    #1;
    chk("mw_exit_3",   b_out, C_BUBBLE);
    chk("mw_exit_1",   a_out, C_ALL);
    tick();
    chk("mw_res_st",   b_state, 2'd1);
    chk("mw_res_out",  b_out, C_BUBBLE);
    tick();
    chk("mw_done_st",  b_state, 2'd0);
    chk("mw_done_out", b_out, C_ALL);
    chk("mw_cnt_3",    b_cnt, 16'd10);
    chk("mw_cnt_1",    a_cnt, 16'd6);

    // Branch and hazard together in RUN: branch wins, FLUSH ignores hazard.
    rm_hazard();
    branch_taken = 1'b1;
    #1;
    chk("br_out_1", a_out, C_BRANCH);
    chk("br_out_3", b_out, C_BRANCH);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("fl_state", a_state, 2'd3);
    chk("fl_out_1", a_out, C_BRANCH);
    chk("fl_out_3", b_out, C_BRANCH);
    tick();
    idle();
    #1;
    chk("fl_done_st", b_state, 2'd0);
    chk("fl_done_o",  b_out, C_ALL);
    chk("fl_cnt_3",   b_cnt, 16'd10);

    // Branch during LSTALL abandons the stall.
    rm_hazard();
    tick();
    idle();
    branch_taken = 1'b1;
    #1;
    chk("ls_br_st",  b_state, 2'd1);
    chk("ls_br_out", b_out, C_BRANCH);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("ls_br_fl",  b_state, 2'd3);
    tick();
    chk("ls_br_run", b_state, 2'd0);
    chk("ls_br_cnt", b_cnt, 16'd11);

    // Branch held through a memory wait is taken once on the exit cycle.
    mem_busy     = 1'b1;
    branch_taken = 1'b1;
    #1;
    chk("hb_busy", a_out, C_ZERO);
    tick();
    chk("hb_mw", a_state, 2'd2);
    tick();
    mem_busy = 1'b0;
    #1;
    chk("hb_exit_1", a_out, C_BRANCH);
    chk("hb_exit_3", b_out, C_BRANCH);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("hb_fl", a_state, 2'd3);
    tick();
    chk("hb_run",   a_state, 2'd0);
    chk("hb_cnt_1", a_cnt, 16'd9);
    chk("hb_cnt_3", b_cnt, 16'd13);

    // Drive the LOAD_LAT=1 counter to 0xFFFE with a long memory wait.
    mem_busy = 1'b1;
    repeat (65525) tick();
    chk("sat_fffe", a_cnt, 16'hFFFE);
    chk("sat_3",    b_cnt, 16'hFFFF);
    tick();
    chk("sat_ffff", a_cnt, 16'hFFFF);
    tick();
    tick();
    chk("sat_hold", a_cnt, 16'hFFFF);
    chk("sat_mw",   a_state, 2'd2);

    // Reset in the middle of MWAIT.
    rst = 1'b1;
    #1;
    chk("rst_mw_out", a_out, C_ZERO);
    tick();
    rst      = 1'b0;
    mem_busy = 1'b0;
    #1;
    chk("rst_mw_st",  a_state, 2'd0);
    chk("rst_mw_cnt", a_cnt, 16'd0);
    chk("rst_mw_o1",  a_out, C_ALL);
    chk("rst_mw_o3",  b_out, C_ALL);
    tick();
    chk("post_rst_cnt", b_cnt, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
